dm_load_store_unit: RTL and testbench
=====================================

Name: dm_load_store_unit

Overview:
- Initiator-side controller that turns core load/store requests into Data_Memory transactions on the RW/EN/ADDr/Din/Dout interface.
- Handles byte, halfword and word accesses.
- Performs load extraction with sign/zero extension, and read-modify-write merge for sub-word stores.
- Sits between the MEM stage of the RISC-V pipeline and Data_Memory; single outstanding request.

Parameters:
- ADDR_W, 32, width of core byte address and of ADDr.
- DATA_W, 32, data word width; fixed at 32, only value supported.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE; request accepted on CLK edge when req_valid&req_ready.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
- req_unsigned  in  1  1=zero-extend load (LBU/LHU), 0=sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse, request complete.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access, valid with rsp_valid.
- RW  out  1  to Data_Memory: 1=write, 0=read.
- EN  out  1  to Data_Memory enable.
- ADDr  out  ADDR_W  word address = latched req_addr>>2.
- Din  out  DATA_W  write word to Data_Memory.
- Dout  in  DATA_W  read word from Data_Memory, valid the cycle after an EN=1,RW=0 cycle.

Behaviour:
Interface and request capture:
- Little-endian; byte lane = addr[1:0], half lane = addr[1].
- Request fields latched on acceptance; inputs ignored outside IDLE.
- req_ready is combinational = (state==IDLE).

FSM states: IDLE, RD, RD_WAIT, WR, RESP.
- Load: IDLE->RD->RD_WAIT->RESP->IDLE. rsp_valid in the 3rd cycle after the acceptance edge.
- Word store: IDLE->WR->RESP->IDLE. rsp_valid in the 2nd cycle after acceptance.
- Sub-word store: IDLE->RD->RD_WAIT->WR->RESP->IDLE.
  - In RD_WAIT, Dout is merged with the store lane(s) into a merge register.
  - WR drives Din = merged word.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): IDLE->RESP with rsp_err=1. No EN cycle is issued.

Memory-side signals:
- EN=1 only in RD and WR. RW=1 only in WR. EN=0 in IDLE, RD_WAIT, RESP.
- ADDr is held stable from RD through WR.

Load data and response:
- Load extraction: byte/half selected by lane.
  - Sign-extended from bit 7/15 when req_unsigned=0, zero-extended otherwise.
  - Word loads are passed unchanged.
- rsp_rdata/rsp_err are registered and held until the next RESP.
- There is no response backpressure.

Reset (async, any state):
- State returns to IDLE.
- EN=0, RW=0, ADDr=0, Din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 after release.
- Reset mid-RMW cancels the pending write; no partial write is ever issued.

Boundaries:
- Back-to-back requests: the next one is accepted in the IDLE cycle following RESP. There is no bubble-free overlap.
- ADDr wraps naturally (addr>>2, upper bits zero).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: misaligned accesses are detected as above and return rsp_err=1 with no memory access.
- Undefined: address low bits are forced aligned (half: addr[0]=0; word: addr[1:0]=0), the access is performed normally, and rsp_err is tied 0.

Test Plan:
- Word 3 = 0x8899AABB. LB addr 0x0D -> rsp_rdata=0xFFFFFFAA. LBU addr 0x0D -> 0x000000AA. Each rsp_valid 3 cycles after acceptance, exactly one EN=1,RW=0 cycle with ADDr=3.
- Word 3 = 0x8899AABB. SH addr 0x0E, wdata 0x00001234 -> one read then one write with ADDr=3, Din=0x1234AABB. Subsequent LW 0x0C returns 0x1234AABB.
- SW addr 0x18, wdata 24 -> single EN=1,RW=1 cycle with ADDr=6, Din=24. rsp_valid 2 cycles after acceptance, rsp_err=0.
- With MISALIGN_TRAP_EN: LW addr 0x0D -> rsp_err=1 the cycle after acceptance, EN never asserted. Without the macro: same request reads ADDr=3, rsp_err=0.
- SB addr 0x04, wdata 0xEE; assert RST during RD_WAIT -> EN=0 immediately, no RW=1 cycle, word 1 unchanged, outputs at reset values, req_ready=1 after release.
- LH addr 0x02 (word 0 = 0x7FFF0000) -> rsp_rdata=0x00007FFF. Issued back-to-back with an SW, the second request is accepted exactly on the IDLE cycle after RESP.

Source files
------------

// File: rtl/dm_load_store_unit_if.sv
// ---------------------------------------------------------------------------
// dm_load_store_unit_if
//
// Bundles the signals between the load/store unit, the core MEM stage and
// Data_Memory into one interface.
//
//   Core request : req_valid, req_ready, req_we, req_size, req_unsigned,
//                  req_addr, req_wdata
//   Core response: rsp_valid, rsp_rdata, rsp_err
//   Memory side  : RW, EN, ADDr, Din (LSU -> memory), Dout (memory -> LSU)
//
// Modports:
//   slave  - the load/store unit itself.
//   master - the environment around it (core MEM stage plus Data_Memory).
// ---------------------------------------------------------------------------
interface dm_load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              RW;
    logic              EN;
    logic [ADDR_W-1:0] ADDr;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, Dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, RW, EN, ADDr, Din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, Dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, RW, EN, ADDr, Din
    );
endinterface

// File: rtl/dm_load_store_unit.sv
// ---------------------------------------------------------------------------
// dm_load_store_unit
//
// Initiator-side controller between the RISC-V MEM stage and Data_Memory.
// Accepts one byte/half/word load or store at a time, performs load
// extraction with sign/zero extension, and does read-modify-write for
// sub-word stores (Data_Memory only writes whole words).
//
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - dm_load_store_unit_if.slave: core request/response plus the
//          Data_Memory RW/EN/ADDr/Din/Dout signals
//
// Optional feature, macro MISALIGN_TRAP_EN:
//   defined   - misaligned half/word accesses go straight to the response
//               with rsp_err=1 and never touch memory.
//   undefined - the low address bits are forced aligned, the access is
//               performed normally and rsp_err is always 0.
// ---------------------------------------------------------------------------
module dm_load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    dm_load_store_unit_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            state_q, state_d;

    // Latched request fields (pure data, not reset)
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;

    // Registered outputs
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              trap;
    logic [1:0]        lane_in;

    // Byte/half/word extraction from a little-endian memory word.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        lane,
        input logic              uns
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        if (size == 2'b00)
            load_extract = uns ? DATA_W'(unsigned'(b)) : DATA_W'(b);
        else if (size == 2'b01)
            load_extract = uns ? DATA_W'(unsigned'(h)) : DATA_W'(h);
        else
            load_extract = word;
    endfunction

    // Insert the store lane(s) into the word read back from memory.
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [DATA_W-1:0] old,
        input logic [15:0]       wdata,
        input logic [1:0]        size,
        input logic [1:0]        lane
    );
        store_merge = old;
        if (size == 2'b00)
            store_merge[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            store_merge[{lane[1], 4'b0000} +: 16] = wdata;
    endfunction

    // Lane selection with the low bits forced aligned for half/word; when
    // trapping, the lane of a misaligned request is never used.
    always_comb begin
        lane_in = bus.req_addr[1:0];
        if (bus.req_size == 2'b01)
            lane_in = {bus.req_addr[1], 1'b0};
        else if (bus.req_size[1])
            lane_in = 2'b00;
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (bus.req_size == 2'b01) ? bus.req_addr[0]
                : (bus.req_size[1] ? (|bus.req_addr[1:0]) : 1'b0);
`else
    assign trap = 1'b0;
`endif

    assign accept = bus.req_valid && (state_q == IDLE);

    // Next state and memory/handshake strobes
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.EN        = 1'b0;
        bus.RW        = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (trap)
                        state_d = RESP;
                    else if (bus.req_we && bus.req_size[1])
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                bus.EN  = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: state_d = we_q ? WR : RESP;
            WR: begin
                bus.EN  = 1'b1;
                bus.RW  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ADDr      = addr_q;
    assign bus.Din       = merge_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Control state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= {2'b00, bus.req_addr[ADDR_W-1:2]};
                // Word stores skip the read, so the write word is known now.
                if (bus.req_we && bus.req_size[1])
                    merge_q <= bus.req_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (accept && trap) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (we_q) begin
                        merge_q <= store_merge(bus.Dout, wdata_q, size_q, lane_q);
                    end else begin
                        rdata_q <= load_extract(bus.Dout, size_q, lane_q, uns_q);
                        err_q   <= 1'b0;
                    end
                end
                WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Request capture
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            lane_q  <= lane_in;
            wdata_q <= bus.req_wdata[15:0];
        end
    end

endmodule

// File: tb/tb_dm_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_dm_load_store_unit
//
// Directed and random load/store requests against a byte-array reference
// model; a small word-addressed Data_Memory model sits on the memory side.
// ---------------------------------------------------------------------------
module tb_dm_load_store_unit;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dm_load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Data_Memory model: synchronous write, read data valid the next cycle.
    logic [31:0] mem [0:15];
    int          wr_total = 0;
    always @(posedge CLK) begin
        if (bus.EN && bus.RW) begin
            mem[bus.ADDr[3:0]] <= bus.Din;
            wr_total           <= wr_total + 1;
        end
        if (bus.EN && !bus.RW)
            bus.Dout <= mem[bus.ADDr[3:0]];
    end

    // Reference memory, byte addressed
    logic [7:0] ref_mem [0:63];

    int tests = 0;
    int fails = 0;

    // Observations from the most recent transaction
    int          o_lat, o_nrd, o_nwr;
    logic [31:0] o_rda, o_wra, o_din, o_rdata;
    logic        o_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Reference behaviour of one request: data, error, latency, memory traffic.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err,
                              output int lat, output int n_rd, output int n_wr);
        int          nb;
        logic [31:0] a;
        logic        mis;
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis   = (addr % nb) != 0;
        rdata = '0;
        err   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            err = 1'b1; lat = 1; n_rd = 0; n_wr = 0;
            return;
        end
`endif
        a = mis ? addr - (addr % nb) : addr;
        if (!we) begin
            for (int i = 0; i < nb; i++)
                rdata = rdata | (32'(ref_mem[a + i]) << (8 * i));
            if (!uns && nb < 4 && rdata[8 * nb - 1])
                rdata = rdata | ~((32'd1 << (8 * nb)) - 32'd1);
            lat = 3; n_rd = 1; n_wr = 0;
        end else begin
            for (int i = 0; i < nb; i++)
                ref_mem[a + i] = wdata[8 * i +: 8];
            lat  = (nb == 4) ? 2 : 4;
            n_rd = (nb == 4) ? 0 : 1;
            n_wr = 1;
        end
    endtask

    // Drive one request from an IDLE cycle and observe it to completion.
    // Garbage with req_valid=1 is presented while busy; it must be ignored.
    task automatic dut_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge CLK); #1;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        o_lat = -1; o_nrd = 0; o_nwr = 0;
        o_rda = '0; o_wra = '0; o_din = '0; o_rdata = '0; o_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.EN) begin
                if (bus.RW) begin
                    o_nwr++; o_wra = bus.ADDr; o_din = bus.Din;
                end else begin
                    o_nrd++; o_rda = bus.ADDr;
                end
            end
            if (bus.rsp_valid) begin
                o_lat = k; o_rdata = bus.rsp_rdata; o_err = bus.rsp_err;
                bus.req_valid = 1'b0;
                break;
            end
            @(posedge CLK); #1;
        end
        bus.req_valid = 1'b0;
        check("ready_in_resp", 32'(bus.req_ready), 32'd0);
        @(posedge CLK); #1;
        check("pulse_end", 32'(bus.rsp_valid), 32'd0);
        check("rdata_hold", bus.rsp_rdata, o_rdata);
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat, e_rd, e_wr;
        ref_access(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_rd, e_wr);
        dut_req(we, size, uns, addr, wdata);
        check({tag, "_lat"},   o_lat, e_lat);
        check({tag, "_err"},   32'(o_err), 32'(e_err));
        check({tag, "_rdata"}, o_rdata, e_rdata);
        check({tag, "_nrd"},   o_nrd, e_rd);
        check({tag, "_nwr"},   o_nwr, e_wr);
        if (e_rd > 0)
            check({tag, "_rdaddr"}, o_rda, addr >> 2);
        if (e_wr > 0) begin
            check({tag, "_wraddr"}, o_wra, addr >> 2);
            check({tag, "_din"},    o_din, ref_word(int'(addr >> 2)));
            check({tag, "_mem"},    mem[addr[5:2]], ref_word(int'(addr >> 2)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] val;
        int          wtot;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Reset state
        @(posedge CLK); #1;
        check("rst_EN",    32'(bus.EN), 32'd0);
        check("rst_RW",    32'(bus.RW), 32'd0);
        check("rst_ADDr",  bus.ADDr, 32'd0);
        check("rst_Din",   bus.Din, 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err",   32'(bus.rsp_err), 32'd0);
        RST = 1'b0;
        check("rst_ready", 32'(bus.req_ready), 32'd1);

        // Preload every word through word stores
        for (int w = 0; w < 16; w++) begin
            val = (w == 0) ? 32'h7FFF0000 : (w == 1) ? 32'h11223344 :
                  (w == 3) ? 32'h8899AABB : $urandom;
            xact("pre", 1'b1, 2'b10, 1'b0, 32'(w * 4), val);
        end

        xact("LB", 1'b0, 2'b00, 1'b0, 32'h0D, 32'h0);
        check("LB_val", o_rdata, 32'hFFFFFFAA);
        check("LB_addr", o_rda, 32'd3);
        xact("LBU", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0);
        check("LBU_val", o_rdata, 32'h000000AA);

        xact("SH", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234);
        check("SH_din", o_din, 32'h1234AABB);
        check("SH_wraddr", o_wra, 32'd3);
        xact("LW", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        check("LW_val", o_rdata, 32'h1234AABB);

        xact("SW", 1'b1, 2'b10, 1'b0, 32'h18, 32'd24);
        check("SW_din", o_din, 32'd24);
        check("SW_addr", o_wra, 32'd6);
        check("SW_lat", o_lat, 32'd2);

        xact("LWmis", 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("LWmis_err", 32'(o_err), 32'd1);
        check("LWmis_lat", o_lat, 32'd1);
        check("LWmis_en", o_nrd + o_nwr, 32'd0);
`else
        check("LWmis_err", 32'(o_err), 32'd0);
        check("LWmis_addr", o_rda, 32'd3);
        check("LWmis_val", o_rdata, 32'h1234AABB);
`endif

        // Back-to-back: the SW is presented in the IDLE cycle right after RESP
        xact("LH", 1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
        check("LH_val", o_rdata, 32'h00007FFF);
        xact("B2B_SW", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE0001);
        check("B2B_lat", o_lat, 32'd2);

        // Random traffic over words 0..15
        for (int n = 0; n < 40; n++)
            xact("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);

        // Leave a non-zero response in the output registers, then
        // reset in the middle of a sub-word store.
        xact("LWpre", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h04; bus.req_wdata = 32'hEE;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        check("rmw_rd_en", 32'(bus.EN), 32'd1);
        @(posedge CLK); #1;
        wtot = wr_total;
        RST = 1'b1;
        #1;
        check("rmw_rst_EN",    32'(bus.EN), 32'd0);
        check("rmw_rst_RW",    32'(bus.RW), 32'd0);
        check("rmw_rst_ADDr",  bus.ADDr, 32'd0);
        check("rmw_rst_Din",   bus.Din, 32'd0);
        check("rmw_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rmw_rst_rdata", bus.rsp_rdata, 32'd0);
        check("rmw_rst_err",   32'(bus.rsp_err), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rmw_ready", 32'(bus.req_ready), 32'd1);
        @(posedge CLK); #1;
        check("rmw_no_write", wr_total, wtot);
        check("rmw_word1", mem[1], ref_word(1));
        xact("post_rst_LW", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
